mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4: maximum consecutive accesses by one owner while the other port is requesting (RR build only).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cpu_req  input  1  CPU requests memory access this cycle.
REQ-005 cpu_we  input  1  1 = write, 0 = read.
REQ-006 cpu_adr  input  32  CPU byte address.
REQ-007 cpu_wdata  input  32  CPU write data.
REQ-008 cpu_gnt  output  1  CPU owns memory (registered).
REQ-009 cpu_rdata  output  32  registered read data for CPU.
REQ-010 cpu_rvalid  output  1  one-cycle pulse: cpu_rdata valid.
REQ-011 dbg_req, dbg_we, dbg_adr[31:0], dbg_wdata[31:0]  input  debug/loader port, same meaning as CPU signals.
REQ-012 dbg_gnt, dbg_rdata[31:0], dbg_rvalid  output  debug port, same meaning as CPU signals.
REQ-013 mem_adr  output  32  address to shared memory.
REQ-014 mem_write_data  output  32  write data to memory.
REQ-015 mem_read  output  1  memory read strobe.
REQ-016 mem_write  output  1  memory write strobe (memory writes on clk edge).
REQ-017 mem_read_data  input  32  combinational memory read data.

Function
REQ-018 FSM states IDLE, OWN_CPU, OWN_DBG; cpu_gnt = (state==OWN_CPU), dbg_gnt = (state==OWN_DBG).
REQ-019 IDLE: no request -> IDLE; single request -> that port's OWN state next cycle; both -> tie-break per REQ-033/034.
REQ-020 Access occurs in every OWN-state cycle where the owner's req is high: mem_adr/mem_write_data from owner; mem_write = we, mem_read = !we.
REQ-021 IDLE, or OWN with owner req low: mem_read = mem_write = 0, mem_adr = 0, mem_write_data = 0.
REQ-022 Read latency: req rises in IDLE at cycle N -> gnt and access at N+1 -> rdata/rvalid at N+2.
REQ-023 On a read access, owner's rdata <= mem_read_data at that edge; owner's rvalid = 1 for exactly the following cycle; otherwise rvalid = 0 and rdata holds.
REQ-024 Writes produce no rvalid.
REQ-025 OWN state with owner req low: other req high -> other OWN state directly; else IDLE.
REQ-026 Burst counter (width clog2(MAX_BURST)+1): clears on entering an OWN state, increments per access, saturates at MAX_BURST.
REQ-027 Never both gnts high; never mem_read and mem_write both high.
REQ-028 Last-served flag updates to the current owner on every OWN-state entry.

Reset
REQ-029 While rst is high, mem_read and mem_write SHALL be forced 0 combinationally (in-flight write suppressed).
REQ-030 On rising edge with rst high: state IDLE, cpu_gnt = dbg_gnt = 0, cpu_rvalid = dbg_rvalid = 0, cpu_rdata = dbg_rdata = 0, burst counter 0, last-served = DBG.
REQ-031 Reset asserted mid-burst aborts ownership; pending rvalid for that cycle is not generated.
REQ-032 First cycle after reset deassertion arbitrates from IDLE.

Configuration
REQ-033 Macro ARB_ROUND_ROBIN_EN defined: IDLE tie -> port not last served; in OWN state, when counter == MAX_BURST and other req high, ownership passes to other port next cycle (access at the switch cycle belongs to the new owner).
REQ-034 Macro undefined: fixed priority, dbg wins IDLE ties; no burst cap, owner keeps grant while its req is high (dbg may starve cpu); MAX_BURST unused.

Verification
REQ-035 After reset, cpu_req=1, we=0, adr=0x10, mem holds 0xDEADBEEF at 0x10 -> cpu_gnt at N+1, mem_read=1, cpu_rdata=0xDEADBEEF with cpu_rvalid pulse at N+2.
REQ-036 cpu_req and dbg_req rise together from reset -> RR build: cpu granted first; non-RR build: dbg granted first.
REQ-037 RR build, MAX_BURST=4, cpu and dbg held high -> grants alternate in blocks of 4 accesses, no idle cycle between blocks.
REQ-038 dbg writes 0x12345678 to 0x40, releases; cpu reads 0x40 -> cpu_rdata = 0x12345678.
REQ-039 rst asserted during a dbg write cycle -> mem_write = 0 that cycle, memory unchanged, all outputs at reset values next cycle.
REQ-040 Throughout all runs, assert gnts one-hot-or-zero and mem_read/mem_write never both high.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug) arbiter in front of a single-ported shared memory.
// Define ARB_ROUND_ROBIN_EN for round-robin with a MAX_BURST cap; otherwise fixed dbg priority.
module mem_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rvalid,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_adr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic [31:0] dbg_rdata,
  output logic        dbg_rvalid,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned CntW = $clog2(MAX_BURST) + 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

  typedef enum logic [1:0] {StIdle, StOwnCpu, StOwnDbg} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] burst_q, burst_d, burst_inc;
  logic            last_dbg_q, last_dbg_d;
  logic            own_req, own_we;
  logic [31:0]     own_adr, own_wdata;
  logic            access, cap_hit, tie_to_cpu;
  logic            rd_cpu, rd_dbg;
  logic [31:0]     cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
  logic            cpu_rvalid_q, cpu_rvalid_d, dbg_rvalid_q, dbg_rvalid_d;

  always_comb begin
    own_req   = 1'b0;
    own_we    = 1'b0;
    own_adr   = '0;
    own_wdata = '0;
    unique case (state_q)
      StOwnCpu: begin
        own_req   = cpu_req;
        own_we    = cpu_we;
        own_adr   = cpu_adr;
        own_wdata = cpu_wdata;
      end
      StOwnDbg: begin
        own_req   = dbg_req;
        own_we    = dbg_we;
        own_adr   = dbg_adr;
        own_wdata = dbg_wdata;
      end
      default: ;
    endcase
  end

  assign access         = own_req;
  assign mem_adr        = access ? own_adr : '0;
  assign mem_write_data = access ? own_wdata : '0;
  // Strobes are gated by reset so an in-flight write never reaches the memory.
  assign mem_read       = access & ~own_we & ~rst;
  assign mem_write      = access & own_we & ~rst;

  assign rd_cpu = (state_q == StOwnCpu) && access && !own_we;
  assign rd_dbg = (state_q == StOwnDbg) && access && !own_we;

  always_comb begin
    burst_inc = burst_q;
    if (access && (burst_q != MaxCnt)) begin
      burst_inc = burst_q + CntW'(1);
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_to_cpu = last_dbg_q;
  // Count including this cycle's access, so a block is exactly MAX_BURST accesses long.
  assign cap_hit    = (burst_inc == MaxCnt);
`else
  assign tie_to_cpu = 1'b0;
  assign cap_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req && dbg_req) begin
          state_d = tie_to_cpu ? StOwnCpu : StOwnDbg;
        end else if (cpu_req) begin
          state_d = StOwnCpu;
        end else if (dbg_req) begin
          state_d = StOwnDbg;
        end
      end
      StOwnCpu: begin
        if (cpu_req) begin
          if (cap_hit && dbg_req) state_d = StOwnDbg;
        end else begin
          state_d = dbg_req ? StOwnDbg : StIdle;
        end
      end
      StOwnDbg: begin
        if (dbg_req) begin
          if (cap_hit && cpu_req) state_d = StOwnCpu;
        end else begin
          state_d = cpu_req ? StOwnCpu : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    burst_d    = burst_inc;
    last_dbg_d = last_dbg_q;
    if ((state_d != state_q) && (state_d != StIdle)) begin
      burst_d    = '0;
      last_dbg_d = (state_d == StOwnDbg);
    end
  end

  always_comb begin
    cpu_rdata_d  = rd_cpu ? mem_read_data : cpu_rdata_q;
    dbg_rdata_d  = rd_dbg ? mem_read_data : dbg_rdata_q;
    cpu_rvalid_d = rd_cpu;
    dbg_rvalid_d = rd_dbg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      burst_q      <= '0;
      last_dbg_q   <= 1'b1;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_q      <= burst_d;
      last_dbg_q   <= last_dbg_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end

  assign cpu_gnt    = (state_q == StOwnCpu);
  assign dbg_gnt    = (state_q == StOwnDbg);
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected read data,
// a monitor pops on every rvalid and also checks grant / strobe exclusivity.
module tb_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit Rr = 1'b1;
`else
  localparam bit Rr = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_adr, cpu_wdata, dbg_adr, dbg_wdata;
  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic [31:0] mem_adr, mem_write_data, mem_read_data;
  logic        mem_read, mem_write;

  logic [31:0] mem [256];

  typedef struct {
    time         due;
    logic [31:0] data;
  } exp_t;

  exp_t exp_cpu[$];
  exp_t exp_dbg[$];
  int   n_vec;
  int   n_bad;

  mem_arbiter #(.MAX_BURST(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_adr       (cpu_adr),
    .cpu_wdata     (cpu_wdata),
    .cpu_gnt       (cpu_gnt),
    .cpu_rdata     (cpu_rdata),
    .cpu_rvalid    (cpu_rvalid),
    .dbg_req       (dbg_req),
    .dbg_we        (dbg_we),
    .dbg_adr       (dbg_adr),
    .dbg_wdata     (dbg_wdata),
    .dbg_gnt       (dbg_gnt),
    .dbg_rdata     (dbg_rdata),
    .dbg_rvalid    (dbg_rvalid),
    .mem_adr       (mem_adr),
    .mem_write_data(mem_write_data),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_read_data (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_adr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_adr[9:2]] <= mem_write_data;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Read data is due at the negedge one clock after the access cycle's negedge.
  task automatic push(input bit to_dbg, input logic [31:0] d);
    exp_t e;
    e.due  = $time + 10;
    e.data = d;
    if (to_dbg) exp_dbg.push_back(e);
    else        exp_cpu.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= '0;
    mem[4]  <= 32'hDEADBEEF;
    mem[8]  <= 32'hC0DE0020;
    mem[9]  <= 32'hDB600024;
    mem[12] <= 32'hA5A50030;
    mem[13] <= 32'h5A5A0034;
    mem[20] <= 32'h0BADF00D;
  end

  initial begin
    bit own_dbg;
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_adr = '0; dbg_wdata = '0;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (cpu_rvalid) begin
            n_vec++;
            if (exp_cpu.size() == 0) begin
              n_bad++;
              $display("FAIL cpu_rvalid_unexpected: got rdata %h, want no rvalid", cpu_rdata);
            end else begin
              e = exp_cpu.pop_front();
              if (cpu_rdata !== e.data || e.due != $time) begin
                n_bad++;
                $display("FAIL cpu_rdata: got %h at t=%0t, want %h at t=%0t",
                         cpu_rdata, $time, e.data, e.due);
              end
            end
          end else if (exp_cpu.size() > 0 && exp_cpu[0].due <= $time) begin
            n_vec++;
            n_bad++;
            e = exp_cpu.pop_front();
            $display("FAIL cpu_rvalid_missing: got none, want %h at t=%0t", e.data, e.due);
          end
          if (dbg_rvalid) begin
            n_vec++;
            if (exp_dbg.size() == 0) begin
              n_bad++;
              $display("FAIL dbg_rvalid_unexpected: got rdata %h, want no rvalid", dbg_rdata);
            end else begin
              e = exp_dbg.pop_front();
              if (dbg_rdata !== e.data || e.due != $time) begin
                n_bad++;
                $display("FAIL dbg_rdata: got %h at t=%0t, want %h at t=%0t",
                         dbg_rdata, $time, e.data, e.due);
              end
            end
          end else if (exp_dbg.size() > 0 && exp_dbg[0].due <= $time) begin
            n_vec++;
            n_bad++;
            e = exp_dbg.pop_front();
            $display("FAIL dbg_rvalid_missing: got none, want %h at t=%0t", e.data, e.due);
          end
          n_vec++;
          if (cpu_gnt && dbg_gnt) begin
            n_bad++;
            $display("FAIL gnt_onehot: got cpu_gnt=1 dbg_gnt=1, want at most one (t=%0t)", $time);
          end
          n_vec++;
          if (mem_read && mem_write) begin
            n_bad++;
            $display("FAIL strobe_excl: got read=1 write=1, want at most one (t=%0t)", $time);
          end
        end
      end
      begin : watchdog
        #50000;
        $display("FAIL watchdog: got no end of test, want finish before t=50000");
        $fatal(1);
      end
    join_none

    // Reset values
    step(); step(); neg();
    chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk1("rst_dbg_gnt", dbg_gnt, 1'b0);
    chk1("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    chk1("rst_dbg_rvalid", dbg_rvalid, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_dbg_rdata", dbg_rdata, 32'h0);
    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);

    // Single CPU read: gnt at N+1, rvalid at N+2
    step(); rst = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h10;
    neg(); chk1("a_idle_gnt", cpu_gnt, 1'b0);
    step(); neg();
    chk1("a_cpu_gnt", cpu_gnt, 1'b1);
    chk1("a_mem_read", mem_read, 1'b1);
    chk1("a_mem_write", mem_write, 1'b0);
    chk("a_mem_adr", mem_adr, 32'h10);
    push(1'b0, 32'hDEADBEEF);
    step(); cpu_req = 1'b0;
    neg();
    chk1("a_cpu_rvalid", cpu_rvalid, 1'b1);
    chk1("a_owner_idle_read", mem_read, 1'b0);
    chk("a_owner_idle_adr", mem_adr, 32'h0);
    step(); neg();
    chk1("a_release_gnt", cpu_gnt, 1'b0);
    chk1("a_rvalid_pulse", cpu_rvalid, 1'b0);
    chk("a_rdata_hold", cpu_rdata, 32'hDEADBEEF);

    // Simultaneous requests from IDLE, then direct hand-off to the other port
    step();
    cpu_req = 1'b1; cpu_adr = 32'h20;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_adr = 32'h24;
    step(); neg();
    chk1("b_first_cpu_gnt", cpu_gnt, Rr);
    chk1("b_first_dbg_gnt", dbg_gnt, !Rr);
    chk("b_first_adr", mem_adr, Rr ? 32'h20 : 32'h24);
    push(!Rr, Rr ? 32'hC0DE0020 : 32'hDB600024);
    step();
    if (Rr) cpu_req = 1'b0;
    else    dbg_req = 1'b0;
    neg(); chk1("b_drop_read", mem_read, 1'b0);
    step(); neg();
    chk1("b_second_cpu_gnt", cpu_gnt, !Rr);
    chk1("b_second_dbg_gnt", dbg_gnt, Rr);
    chk("b_second_adr", mem_adr, Rr ? 32'h24 : 32'h20);
    push(Rr, Rr ? 32'hDB600024 : 32'hC0DE0020);
    step(); cpu_req = 1'b0; dbg_req = 1'b0;
    neg();
    step(); neg();
    chk1("b_idle_cpu_gnt", cpu_gnt, 1'b0);
    chk1("b_idle_dbg_gnt", dbg_gnt, 1'b0);

    // Both held high: RR alternates in blocks of 4, fixed priority starves cpu
    step();
    cpu_req = 1'b1; cpu_adr = 32'h30;
    dbg_req = 1'b1; dbg_adr = 32'h34;
    for (int k = 0; k < 10; k++) begin
      step(); neg();
      own_dbg = Rr ? (((k / 4) % 2) == 1) : 1'b1;
      chk1($sformatf("c_cpu_gnt_%0d", k), cpu_gnt, !own_dbg);
      chk1($sformatf("c_dbg_gnt_%0d", k), dbg_gnt, own_dbg);
      chk($sformatf("c_adr_%0d", k), mem_adr, own_dbg ? 32'h34 : 32'h30);
      push(own_dbg, own_dbg ? 32'h5A5A0034 : 32'hA5A50030);
    end
    step(); cpu_req = 1'b0; dbg_req = 1'b0;
    neg(); chk1("c_drop_read", mem_read, 1'b0);
    step(); neg();
    chk1("c_idle_cpu_gnt", cpu_gnt, 1'b0);
    chk1("c_idle_dbg_gnt", dbg_gnt, 1'b0);

    // dbg write then cpu read-back of the same word
    step();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_adr = 32'h40; dbg_wdata = 32'h12345678;
    step(); neg();
    chk1("d_dbg_gnt", dbg_gnt, 1'b1);
    chk1("d_mem_write", mem_write, 1'b1);
    chk1("d_mem_read", mem_read, 1'b0);
    chk("d_mem_adr", mem_adr, 32'h40);
    chk("d_mem_wdata", mem_write_data, 32'h12345678);
    step();
    dbg_req = 1'b0; dbg_we = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h40;
    neg();
    chk1("d_release_write", mem_write, 1'b0);
    chk1("d_release_gnt", dbg_gnt, 1'b1);
    step(); neg();
    chk1("d_cpu_gnt", cpu_gnt, 1'b1);
    chk1("d_cpu_read", mem_read, 1'b1);
    chk("d_mem_word", mem[16], 32'h12345678);
    push(1'b0, 32'h12345678);
    step(); cpu_req = 1'b0;
    neg();
    step(); neg();

    // Reset during a dbg write cycle
    step();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_adr = 32'h50; dbg_wdata = 32'h55AA55AA;
    step(); rst = 1'b1;
    neg();
    chk1("e_gnt_before_reset", dbg_gnt, 1'b1);
    chk1("e_write_forced", mem_write, 1'b0);
    chk1("e_read_forced", mem_read, 1'b0);
    step(); rst = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
    neg();
    chk1("e_cpu_gnt", cpu_gnt, 1'b0);
    chk1("e_dbg_gnt", dbg_gnt, 1'b0);
    chk("e_cpu_rdata", cpu_rdata, 32'h0);
    chk("e_dbg_rdata", dbg_rdata, 32'h0);
    chk1("e_cpu_rvalid", cpu_rvalid, 1'b0);
    chk1("e_dbg_rvalid", dbg_rvalid, 1'b0);
    chk("e_mem_unchanged", mem[20], 32'h0BADF00D);

    // Reset mid CPU burst: read in the reset cycle yields no rvalid; re-arbitrate from IDLE
    step(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h10;
    step(); neg();
    chk1("f_cpu_gnt", cpu_gnt, 1'b1);
    chk1("f_mem_read", mem_read, 1'b1);
    push(1'b0, 32'hDEADBEEF);
    step(); rst = 1'b1;
    neg();
    chk1("f_read_forced", mem_read, 1'b0);
    chk1("f_prev_rvalid", cpu_rvalid, 1'b1);
    step(); rst = 1'b0;
    neg();
    chk1("f_post_rst_gnt", cpu_gnt, 1'b0);
    chk1("f_aborted_rvalid", cpu_rvalid, 1'b0);
    chk("f_post_rst_rdata", cpu_rdata, 32'h0);
    step(); neg();
    chk1("f_regrant", cpu_gnt, 1'b1);
    chk1("f_reread", mem_read, 1'b1);
    push(1'b0, 32'hDEADBEEF);
    step(); cpu_req = 1'b0;
    neg();
    step(); neg();
    step(); neg();

    chk("sb_cpu_drained", 32'(exp_cpu.size()), 32'd0);
    chk("sb_dbg_drained", 32'(exp_dbg.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
